// File: rtl/sum_register_seq.sv
// ---------------------------------------------------------------------------
// sum_register_seq
//
// AXI4-Lite master sequencer for the sum_register slave. A client hands over
// an operand pair (A, B) on a valid/ready request port; the sequencer writes
// A to slave offset 0x0 and B to offset 0x4, reads the sum back from offset
// 0x8, and returns it with an error flag on a valid/ready response port.
// Only one operation is in flight at a time. The block does no arithmetic;
// the sum, including its wrap modulo 2^32, comes from the slave.
//
// Ports:
//   ACLK, ARESET         clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready is high only in IDLE
//   req_a, req_b         operands, latched on the request handshake
//   rsp_valid/rsp_ready  response handshake; data held stable until accepted
//   rsp_sum, rsp_err     slave sum (forced to 0 on error), any non-OKAY resp
//   busy                 high whenever the sequencer is not idle
//   M_AXI_*              AXI4-Lite master port (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module sum_register_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  // client request port
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] req_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] req_b,
  // client response port
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_sum,
  output logic                          rsp_err,
  output logic                          busy,
  // AXI write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  // AXI write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  // AXI write response channel
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  // AXI read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  // AXI read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  // Register offsets inside the sum_register slave.
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFF_A   = C_M_AXI_ADDR_WIDTH'(32'h0000_0000);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFF_B   = C_M_AXI_ADDR_WIDTH'(32'h0000_0004);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFF_SUM = C_M_AXI_ADDR_WIDTH'(32'h0000_0008);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Absolute slave address for a register offset.
  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] slave_addr(
    input logic [C_M_AXI_ADDR_WIDTH-1:0] offset
  );
    return C_BASE_ADDR + offset;
  endfunction

  // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is an error here.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

  // Sequencer state and registered outputs.
  state_t                          state_r;
  logic                            req_ready_r;
  logic                            busy_r;
  logic                            rsp_valid_r;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_sum_r;
  logic                            err_r;
  logic [C_M_AXI_DATA_WIDTH-1:0]   op_b_r;      // B waits here while A is written
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r;
  logic                            awvalid_r;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;     // also serves as the A latch
  logic                            wvalid_r;
  logic                            bready_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r;
  logic                            arvalid_r;
  logic                            rready_r;
  // Per-write-phase progress: AW and W complete independently.
  logic                            aw_done_r;
  logic                            w_done_r;

  // Handshake strobes and "completed by the end of this cycle" views.
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;
  logic aw_done_s;
  logic w_done_s;

  // Channel handshake decode; these only feed registers, never outputs.
  always_comb begin
    aw_hs_s   = awvalid_r & M_AXI_AWREADY;
    w_hs_s    = wvalid_r  & M_AXI_WREADY;
    b_hs_s    = bready_r  & M_AXI_BVALID;
    ar_hs_s   = arvalid_r & M_AXI_ARREADY;
    r_hs_s    = rready_r  & M_AXI_RVALID;
    aw_done_s = aw_done_r | aw_hs_s;
    w_done_s  = w_done_r  | w_hs_s;
  end

  // Sequencer FSM driving every client and AXI output from registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_sum_r   <= '0;
      err_r       <= 1'b0;
      op_b_r      <= '0;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            // Launch the A write straight away: AW and W go up together.
            op_b_r      <= req_b;
            awaddr_r    <= slave_addr(OFF_A);
            wdata_r     <= req_a;
            awvalid_r   <= 1'b1;
            wvalid_r    <= 1'b1;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_WR_A;
          end
        end

        ST_WR_A, ST_WR_B: begin
          // Each VALID drops the cycle after its own handshake.
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (bready_r) begin
            if (b_hs_s) begin
              bready_r  <= 1'b0;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              if (resp_is_err(M_AXI_BRESP)) begin
                // A failed write abandons the rest of the operation.
                err_r       <= 1'b1;
                rsp_sum_r   <= '0;
                rsp_valid_r <= 1'b1;
                state_r     <= ST_RESP;
              end else if (state_r == ST_WR_A) begin
                awaddr_r  <= slave_addr(OFF_B);
                wdata_r   <= op_b_r;
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
                state_r   <= ST_WR_B;
              end else begin
                araddr_r  <= slave_addr(OFF_SUM);
                arvalid_r <= 1'b1;
                state_r   <= ST_RD;
              end
            end
          end else if (aw_done_s && w_done_s) begin
            // Both halves of the write are through; now take the response.
            bready_r <= 1'b1;
          end
        end

        ST_RD: begin
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
          if (r_hs_s) begin
            rready_r    <= 1'b0;
            err_r       <= resp_is_err(M_AXI_RRESP);
            rsp_sum_r   <= resp_is_err(M_AXI_RRESP) ? '0 : M_AXI_RDATA;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Result held stable until the client takes it.
          if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_sum_r   <= '0;
            err_r       <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end

        default: begin
          // Unreachable encodings fall back to a clean idle.
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_sum_r   <= '0;
          err_r       <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          aw_done_r   <= 1'b0;
          w_done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping: every output is a register or a constant.
  assign req_ready     = req_ready_r;
  assign busy          = busy_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_sum       = rsp_sum_r;
  assign rsp_err       = err_r;
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_sum_register_seq.sv
// ---------------------------------------------------------------------------
// tb_sum_register_seq
//
// Directed bench for sum_register_seq. A behavioural AXI4-Lite sum_register
// slave (negedge driven, configurable AW/W ready delays, optional SLVERR on
// the B write) sits on the master port. A reference queue records, for every
// accepted request, the result the client must receive ((A+B) mod 2^32, or
// 0 with err=1 when a write error is injected); a compare process checks the
// response port against it on every cycle rsp_valid is high.
// ---------------------------------------------------------------------------
module tb_sum_register_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_err, busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  sum_register_seq #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(BASE)
  ) dut (
    .ACLK(clk), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0;
  bit          inj_werr_b = 1'b0;
  bit          slave_hold = 1'b0;
  int          aw_cnt, w_cnt, aw_len, w_len, last_aw_len, last_w_len, ar_count;
  bit          got_aw, got_w, b_pend;
  logic [31:0] s_awaddr, s_wdata, last_araddr;
  logic [31:0] regs [0:3];
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  logic        l_awvalid, l_wvalid, l_bready, l_arvalid, l_rready;
  logic [31:0] l_awaddr, l_wdata, l_araddr;

  task automatic slave_reset();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
    aw_cnt = 0; w_cnt = 0; aw_len = 0; w_len = 0;
    got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0;
    l_awvalid = 1'b0; l_wvalid = 1'b0; l_bready = 1'b0; l_arvalid = 1'b0; l_rready = 1'b0;
    l_awaddr = 32'h0; l_wdata = 32'h0; l_araddr = 32'h0;
    for (int i = 0; i < 4; i++) regs[i] = 32'h0;
  endtask

  // Slave acts on negedges: first resolve handshakes of the last posedge,
  // then set up READY/VALID for the next one.
  always @(negedge clk) begin
    if (slave_hold) begin
      slave_reset();
    end else begin
      if (l_bready && M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0;
      end
      if (l_rready && M_AXI_RVALID) M_AXI_RVALID = 1'b0;
      if (l_awvalid && M_AXI_AWREADY) begin
        got_aw = 1'b1; s_awaddr = l_awaddr; last_aw_len = aw_len; aw_len = 0; aw_cnt = 0;
      end
      if (l_wvalid && M_AXI_WREADY) begin
        got_w = 1'b1; s_wdata = l_wdata; last_w_len = w_len; w_len = 0; w_cnt = 0;
      end
      if (l_arvalid && M_AXI_ARREADY) begin
        ar_count++; last_araddr = l_araddr;
        M_AXI_RDATA = regs[0] + regs[1]; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b1;
      end
      if (got_aw && got_w && !b_pend) begin
        logic [31:0] idx;
        b_pend = 1'b1;
        wlog_addr.push_back(s_awaddr); wlog_data.push_back(s_wdata);
        idx = (s_awaddr - BASE) >> 2;
        if (inj_werr_b && s_awaddr == BASE + 32'h4) M_AXI_BRESP = 2'b10;
        else begin M_AXI_BRESP = 2'b00; regs[idx[1:0]] = s_wdata; end
        M_AXI_BVALID = 1'b1;
      end
      if (M_AXI_BREADY) chk("bready_after_aw_and_w", {31'h0, got_aw && got_w}, 32'h1);
      if (M_AXI_AWVALID) aw_len++;
      if (M_AXI_WVALID) w_len++;
      M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
      if (M_AXI_AWVALID) aw_cnt++;
      M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_delay);
      if (M_AXI_WVALID) w_cnt++;
      M_AXI_ARREADY = M_AXI_ARVALID;
      l_awvalid = M_AXI_AWVALID; l_wvalid = M_AXI_WVALID; l_bready = M_AXI_BREADY;
      l_arvalid = M_AXI_ARVALID; l_rready = M_AXI_RREADY;
      l_awaddr = M_AXI_AWADDR; l_wdata = M_AXI_WDATA; l_araddr = M_AXI_ARADDR;
    end
  end

  // ---------------- reference model + compare ----------------
  logic [31:0] exp_sum [$];
  logic        exp_err [$];
  int          n_accept = 0;

  always @(negedge clk) begin
    if (!ARESET) begin
      if (req_valid && req_ready) begin
        n_accept++;
        if (inj_werr_b) begin exp_sum.push_back(32'h0); exp_err.push_back(1'b1); end
        else begin exp_sum.push_back(req_a + req_b); exp_err.push_back(1'b0); end
      end
      if (rsp_valid) begin
        chk("rsp_has_expected", {31'h0, exp_sum.size() > 0}, 32'h1);
        if (exp_sum.size() > 0) begin
          chk("model_rsp_sum", rsp_sum, exp_sum[0]);
          chk("model_rsp_err", {31'h0, rsp_err}, {31'h0, exp_err[0]});
          if (rsp_ready) begin
            void'(exp_sum.pop_front()); void'(exp_err.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_awvalid"}, {31'h0, M_AXI_AWVALID}, 32'h0);
    chk({tag, "_wvalid"}, {31'h0, M_AXI_WVALID}, 32'h0);
    chk({tag, "_bready"}, {31'h0, M_AXI_BREADY}, 32'h0);
    chk({tag, "_arvalid"}, {31'h0, M_AXI_ARVALID}, 32'h0);
    chk({tag, "_rready"}, {31'h0, M_AXI_RREADY}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_sum"}, rsp_sum, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic do_req(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 32'h0, 32'h1);
  endtask

  // Wait for the response handshake (rsp_ready assumed high) and return it.
  task automatic wait_rsp(output logic [31:0] sum, output logic err);
    bit ok;
    ok = 1'b0; sum = 32'hDEAD_BEEF; err = 1'bx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1'b1; sum = rsp_sum; err = rsp_err; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk("rsp_timeout", 32'h0, 32'h1);
  endtask

  logic [31:0] s;
  logic        e;
  int          ar0, n0;
  bit          ok_w, hs_seen;

  initial begin
    slave_reset();
    ARESET = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_awprot", {29'h0, M_AXI_AWPROT}, 32'h0);
    chk("reset_wstrb", {28'h0, M_AXI_WSTRB}, 32'hF);
    ARESET = 1'b0;
    @(posedge clk); #1;

    // Basic
    wlog_addr.delete(); wlog_data.delete();
    do_req(32'd5, 32'd7);
    wait_rsp(s, e);
    chk("basic_sum", s, 32'h0000_000C);
    chk("basic_err", {31'h0, e}, 32'h0);
    chk("basic_nwrites", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("basic_wr0_addr", wlog_addr[0], BASE + 32'h0);
      chk("basic_wr0_data", wlog_data[0], 32'h5);
      chk("basic_wr1_addr", wlog_addr[1], BASE + 32'h4);
      chk("basic_wr1_data", wlog_data[1], 32'h7);
    end
    chk("basic_araddr", last_araddr, BASE + 32'h8);
    check_idle("after_basic");

    // Wrap
    do_req(32'hFFFF_FFFF, 32'h2);
    wait_rsp(s, e);
    chk("wrap_sum", s, 32'h0000_0001);
    chk("wrap_err", {31'h0, e}, 32'h0);

    // Channel skew: AW late, then W late
    aw_delay = 3; w_delay = 0;
    do_req(32'd100, 32'd23);
    wait_rsp(s, e);
    chk("skew_aw_sum", s, 32'd123);
    chk("skew_aw_awvalid_len", last_aw_len, 32'd4);
    chk("skew_aw_wvalid_len", last_w_len, 32'd1);
    aw_delay = 0; w_delay = 3;
    do_req(32'd40, 32'd2);
    wait_rsp(s, e);
    chk("skew_w_sum", s, 32'd42);
    chk("skew_w_awvalid_len", last_aw_len, 32'd1);
    chk("skew_w_wvalid_len", last_w_len, 32'd4);
    w_delay = 0;

    // Error on the B write: no read, err=1, sum=0; then a clean op
    inj_werr_b = 1'b1; ar0 = ar_count;
    do_req(32'd9, 32'd9);
    wait_rsp(s, e);
    inj_werr_b = 1'b0;
    chk("err_sum", s, 32'h0);
    chk("err_flag", {31'h0, e}, 32'h1);
    chk("err_no_ar", ar_count, ar0);
    do_req(32'd1, 32'd1);
    wait_rsp(s, e);
    chk("after_err_sum", s, 32'd2);
    chk("after_err_err", {31'h0, e}, 32'h0);

    // Response backpressure
    rsp_ready = 1'b0;
    do_req(32'd10, 32'd20);
    ok_w = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok_w = 1'b1; break; end
    end
    if (!ok_w) chk("bp_rsp_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_a = 32'd77; req_b = 32'd88; req_valid = 1'b1; n0 = n_accept;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_sum", rsp_sum, 32'd30);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    chk("bp_no_accept", n_accept, n0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    ok_w = 1'b0; hs_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok_w = 1'b1; break; end
      if (rsp_valid && rsp_ready) hs_seen = 1'b1;
    end
    chk("bp_accept_after_rsp", {31'h0, ok_w && hs_seen}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(s, e);
    chk("bp_second_sum", s, 32'd165);

    // Reset during WR_B with AWVALID high
    aw_delay = 3;
    do_req(32'd50, 32'd60);
    ok_w = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (M_AXI_AWVALID && M_AXI_AWADDR == BASE + 32'h4) begin ok_w = 1'b1; break; end
    end
    chk("rst_reached_wr_b", {31'h0, ok_w}, 32'h1);
    chk("rst_busy_mid_op", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    ARESET = 1'b1; slave_hold = 1'b1;
    @(posedge clk); #1;
    ARESET = 1'b0;
    check_idle("mid_op_reset");
    exp_sum.delete(); exp_err.delete();
    slave_reset(); slave_hold = 1'b0; aw_delay = 0;
    @(posedge clk); #1;
    do_req(32'd3, 32'd4);
    wait_rsp(s, e);
    chk("post_reset_sum", s, 32'd7);
    chk("post_reset_err", {31'h0, e}, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
